// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding helpers, peripheral state set and
// the default byte returned when the host has nothing queued.
package spi_pkg;

    typedef logic [1:0] spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } periph_state_t;

    localparam logic [7:0] DEF_IDLE_MISO_BYTE = 8'hFF;

    function automatic logic cpol(input spi_mode_t mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input spi_mode_t mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_peripheral_w_cs_if.sv
// Host-side byte handshake plus SPI pins of the peripheral endpoint.
// slave = the peripheral itself, master = host logic / external controller.
interface spi_peripheral_w_cs_if #(
    parameter int COUNT_W = 2
);
    logic [7:0]         i_MISO_Byte;
    logic               i_MISO_DV;
    logic               o_MISO_Ready;
    logic [7:0]         o_MOSI_Byte;
    logic               o_MOSI_DV;
    logic [COUNT_W-1:0] o_MOSI_Count;
    logic               o_Frame_Done;
    logic               o_Frame_Err;
    logic               SCK;
    logic               CS_L;
    logic               MOSI;
    logic               MISO;
    logic               o_MISO_En;

    modport slave (
        input  i_MISO_Byte, i_MISO_DV, SCK, CS_L, MOSI,
        output o_MISO_Ready, o_MOSI_Byte, o_MOSI_DV, o_MOSI_Count,
               o_Frame_Done, o_Frame_Err, MISO, o_MISO_En
    );

    modport master (
        output i_MISO_Byte, i_MISO_DV, SCK, CS_L, MOSI,
        input  o_MISO_Ready, o_MOSI_Byte, o_MOSI_DV, o_MOSI_Count,
               o_Frame_Done, o_Frame_Err, MISO, o_MISO_En
    );
endinterface

// File: rtl/spi_sync_edge.sv
// SYNC_STAGES-deep (>= 2) synchronizer with registered rise/fall pulses.
// Edges are only reported once the pipeline has filled after reset.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] pipe;
    logic [SYNC_STAGES-1:0] vld;
    logic                   prev;
    logic                   prev_vld;

    assign sync = pipe[SYNC_STAGES-1];

    // A level already present at reset release must not look like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe     <= {SYNC_STAGES{RST_VAL}};
            vld      <= '0;
            prev     <= RST_VAL;
            prev_vld <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            pipe     <= {pipe[SYNC_STAGES-2:0], din};
            vld      <= {vld[SYNC_STAGES-2:0], 1'b1};
            prev     <= pipe[SYNC_STAGES-1];
            prev_vld <= vld[SYNC_STAGES-1];
            rise     <= vld[SYNC_STAGES-1] & prev_vld &  pipe[SYNC_STAGES-1] & ~prev;
            fall     <= vld[SYNC_STAGES-1] & prev_vld & ~pipe[SYNC_STAGES-1] &  prev;
        end
    end
endmodule

// File: rtl/spi_peripheral_w_cs.sv
// SPI peripheral endpoint with CS_L-framed byte transfers, oversampled in clk.
// Optional SPI_PERIPH_FRAME_ERR_EN: flag frames ending on a partial byte.
module spi_peripheral_w_cs
    import spi_pkg::*;
#(
    parameter int         SPI_MODE         = 0,
    parameter int         MAX_BYTES_PER_CS = 2,
    parameter int         SYNC_STAGES      = 2,
    parameter logic [7:0] IDLE_MISO_BYTE   = DEF_IDLE_MISO_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_peripheral_w_cs_if.slave bus
);
    localparam int        COUNT_W        = $clog2(MAX_BYTES_PER_CS + 1);
    localparam spi_mode_t MODE           = spi_mode_t'(SPI_MODE);
    localparam logic      SAMPLE_ON_RISE = (cpol(MODE) == cpha(MODE));
    localparam logic      MODE_CPHA      = cpha(MODE);
    localparam logic [COUNT_W-1:0] IDX_MAX = COUNT_W'(MAX_BYTES_PER_CS);

    logic sck_sync_unused, sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .din(bus.SCK),
        .sync(sck_sync_unused), .rise(sck_rise), .fall(sck_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(bus.CS_L),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(bus.MOSI),
        .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    periph_state_t      state;
    logic [2:0]         bit_cnt;
    logic [COUNT_W-1:0] byte_idx;
    logic [COUNT_W-1:0] mosi_cnt;
    logic [7:0]         rx_sr, tx_sr, hold, mosi_byte;
    logic               ready, mosi_dv, frame_done, frame_err, miso;
    logic               sample_edge, shift_edge, partial;
    logic [7:0]         next_tx;

    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
    assign next_tx     = ready ? IDLE_MISO_BYTE : hold;

`ifdef SPI_PERIPH_FRAME_ERR_EN
    assign partial = (bit_cnt != 3'd0);
`else
    assign partial = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            mosi_cnt   <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            hold       <= '0;
            mosi_byte  <= '0;
            ready      <= 1'b1;
            mosi_dv    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b1;
        end else begin
            mosi_dv    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (bus.i_MISO_DV && ready) begin
                hold  <= bus.i_MISO_Byte;
                ready <= 1'b0;
            end

            if (cs_rise) begin
                state      <= IDLE;
                frame_done <= 1'b1;
                frame_err  <= partial;
                bit_cnt    <= '0;
                byte_idx   <= '0;
                miso       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state   <= ACTIVE;
                            bit_cnt <= '0;
                            rx_sr   <= '0;
                            if (!ready) ready <= 1'b1;
                            // CPHA=0 needs bit7 on the wire before the first sample edge.
                            if (!MODE_CPHA) begin
                                miso  <= next_tx[7];
                                tx_sr <= {next_tx[6:0], 1'b0};
                            end else begin
                                tx_sr <= next_tx;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (sample_edge) begin
                            rx_sr   <= {rx_sr[6:0], mosi_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                mosi_byte <= {rx_sr[6:0], mosi_sync};
                                mosi_dv   <= 1'b1;
                                mosi_cnt  <= byte_idx;
                                if (byte_idx != IDX_MAX) byte_idx <= byte_idx + 1'b1;
                                tx_sr     <= next_tx;
                                if (!ready) ready <= 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            miso  <= tx_sr[7];
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_MISO_Ready = ready;
    assign bus.o_MOSI_Byte  = mosi_byte;
    assign bus.o_MOSI_DV    = mosi_dv;
    assign bus.o_MOSI_Count = mosi_cnt;
    assign bus.o_Frame_Done = frame_done;
    assign bus.o_Frame_Err  = frame_err;
    assign bus.MISO         = miso;
    assign bus.o_MISO_En    = ~cs_sync;
endmodule
